osc_meas_sequencer: RTL and testbench

Measurement scheduler for the ring-oscillator temperature sensor. It sequences one or both ring oscillators through settle, counter clear, gate window, synchronizer hold and capture. Each captured count is presented on a valid/ready result port for the averaging/UART path. It replaces the static pin-driven oscillator enables and select with a timed, repeatable measurement cycle.

---
 rtl/osc_meas_sequencer.sv | 160 ++++++++++++++++
 tb/tb_osc_meas_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/osc_meas_sequencer.sv
// Ring-oscillator measurement scheduler: settle, counter clear, gate window, sync hold,
// capture, then a valid/ready result handshake with optional alternate and continuous rounds.
module osc_meas_sequencer #(
    parameter int WIDTH         = 16,
    parameter int SETTLE_CYCLES = 16,
    parameter int GATE_CYCLES   = 1000,
    parameter int SYNC_CYCLES   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             continuous,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] cnt_value,
    output logic             osc_en_inv,
    output logic             osc_en_nand,
    output logic             osc_sel,
    output logic             cnt_clr,
    output logic             cnt_gate,
    output logic [WIDTH-1:0] res_data,
    output logic             res_id,
    output logic             res_sat,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             busy
);

    typedef enum logic [2:0] {
        IDLE, SETTLE, CLEAR, GATE, HOLD, CAPTURE, OUTPUT
    } state_t;

    // Timer counts down to zero, so each load is the state length minus one.
    localparam logic [15:0] SETTLE_LD = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] GATE_LD   = 16'(GATE_CYCLES - 1);
    localparam logic [15:0] SYNC_LD   = 16'(SYNC_CYCLES - 1);

    state_t            state_q, state_d;
    logic [15:0]       timer_q, timer_d;
    logic [1:0]        mode_q, mode_d;
    logic              cur_osc_q, cur_osc_d;
    logic              run_d;
    logic              alt_mode;
    logic              xfer;

    logic              osc_en_inv_q, osc_en_nand_q, osc_sel_q;
    logic              cnt_clr_q, cnt_gate_q, busy_q;
    logic [WIDTH-1:0]  res_data_q;
    logic              res_id_q, res_sat_q, res_valid_q;

    assign alt_mode = (mode_q == 2'b10) || (mode_q == 2'b11);
    assign xfer     = res_valid_q & res_ready;

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        mode_d    = mode_q;
        cur_osc_d = cur_osc_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d    = mode;
                    cur_osc_d = (mode == 2'b01);
                    state_d   = SETTLE;
                    timer_d   = SETTLE_LD;
                end
            end
            SETTLE: begin
                if (timer_q == 16'd0) state_d = CLEAR;
                else                  timer_d = timer_q - 16'd1;
            end
            CLEAR: begin
                state_d = GATE;
                timer_d = GATE_LD;
            end
            GATE: begin
                if (timer_q == 16'd0) begin
                    state_d = HOLD;
                    timer_d = SYNC_LD;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            HOLD: begin
                if (timer_q == 16'd0) state_d = CAPTURE;
                else                  timer_d = timer_q - 16'd1;
            end
            CAPTURE: state_d = OUTPUT;
            OUTPUT: begin
                if (xfer) begin
                    // Second half of an alternate round takes priority over the round boundary.
                    if (alt_mode && !cur_osc_q) begin
                        cur_osc_d = 1'b1;
                        state_d   = SETTLE;
                        timer_d   = SETTLE_LD;
                    end else if (continuous) begin
                        mode_d    = mode;
                        cur_osc_d = (mode == 2'b01);
                        state_d   = SETTLE;
                        timer_d   = SETTLE_LD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        run_d = (state_d == SETTLE) || (state_d == CLEAR) || (state_d == GATE);
    end

    // Outputs are registered from the next state so they align with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            timer_q       <= 16'd0;
            mode_q        <= 2'b00;
            cur_osc_q     <= 1'b0;
            osc_en_inv_q  <= 1'b0;
            osc_en_nand_q <= 1'b0;
            osc_sel_q     <= 1'b0;
            cnt_clr_q     <= 1'b0;
            cnt_gate_q    <= 1'b0;
            busy_q        <= 1'b0;
            res_data_q    <= '0;
            res_id_q      <= 1'b0;
            res_sat_q     <= 1'b0;
            res_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            mode_q        <= mode_d;
            cur_osc_q     <= cur_osc_d;
            osc_en_inv_q  <= run_d & ~cur_osc_d;
            osc_en_nand_q <= run_d & cur_osc_d;
            if (run_d) osc_sel_q <= cur_osc_d;
            cnt_clr_q     <= (state_d == CLEAR);
            cnt_gate_q    <= (state_d == GATE);
            busy_q        <= (state_d != IDLE);
            if (state_q == CAPTURE) begin
                res_data_q  <= cnt_value;
                res_id_q    <= cur_osc_q;
                res_sat_q   <= &cnt_value;
                res_valid_q <= 1'b1;
            end else if (xfer) begin
                res_valid_q <= 1'b0;
            end
        end
    end

    assign osc_en_inv  = osc_en_inv_q;
    assign osc_en_nand = osc_en_nand_q;
    assign osc_sel     = osc_sel_q;
    assign cnt_clr     = cnt_clr_q;
    assign cnt_gate    = cnt_gate_q;
    assign busy        = busy_q;
    assign res_data    = res_data_q;
    assign res_id      = res_id_q;
    assign res_sat     = res_sat_q;
    assign res_valid   = res_valid_q;

endmodule

// File: tb/tb_osc_meas_sequencer.sv
// Bench for osc_meas_sequencer: cycle-window checks of the round timing plus a result
// scoreboard filled at start time and drained on every valid/ready transfer.
module tb_osc_meas_sequencer;
    localparam int W = 16;
    localparam int S = 4;
    localparam int G = 10;
    localparam int Y = 2;
    localparam int VLD = S + 3 + G + Y;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, start, continuous, res_ready;
    logic [1:0]   mode;
    logic [W-1:0] cnt_value;
    logic         osc_en_inv, osc_en_nand, osc_sel, cnt_clr, cnt_gate;
    logic [W-1:0] res_data;
    logic         res_id, res_sat, res_valid, busy;

    osc_meas_sequencer #(
        .WIDTH(W), .SETTLE_CYCLES(S), .GATE_CYCLES(G), .SYNC_CYCLES(Y)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous), .mode(mode),
        .cnt_value(cnt_value), .osc_en_inv(osc_en_inv), .osc_en_nand(osc_en_nand),
        .osc_sel(osc_sel), .cnt_clr(cnt_clr), .cnt_gate(cnt_gate), .res_data(res_data),
        .res_id(res_id), .res_sat(res_sat), .res_valid(res_valid), .res_ready(res_ready),
        .busy(busy)
    );

    typedef struct packed {
        logic [W-1:0] data;
        logic         id;
        logic         sat;
    } res_t;

    typedef struct {
        logic [1:0]   mode;
        logic [W-1:0] cnt;
        logic [W-1:0] exp_data;
        logic         exp_id;
        logic         exp_sat;
        logic         alt;
    } vec_t;

    res_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic push_res(input logic [W-1:0] d, input logic id, input logic sat);
        res_t e;
        e.data = d;
        e.id   = id;
        e.sat  = sat;
        sb.push_back(e);
    endtask

    // Finish the current cycle: scoreboard any transfer mid-cycle, then step past the edge.
    task automatic tick();
        res_t e;
        @(negedge clk);
        if (!rst && res_valid === 1'b1 && res_ready === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_extra cyc=%0d got=%h/%b/%b want=none", cyc, res_data, res_id, res_sat);
            end else begin
                e = sb.pop_front();
                if ({res_data, res_id, res_sat} !== e) begin
                    bad++;
                    $display("FAIL sb_result cyc=%0d got=%h/%b/%b want=%h/%b/%b",
                             cyc, res_data, res_id, res_sat, e.data, e.id, e.sat);
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_idle(input int maxc);
        int n = 0;
        while (busy !== 1'b0 && n < maxc) begin
            tick();
            n++;
        end
        chk1("idle_within_bound", busy, 1'b0);
    endtask

    task automatic chk_all_zero(input string name);
        chkw(name, {7'b0, osc_en_inv, osc_en_nand, osc_sel, cnt_clr, cnt_gate,
                    res_id, res_sat, res_valid, busy}, 16'h0000);
        chkw({name, "_data"}, res_data, 16'h0000);
    endtask

    vec_t tbl[6];

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{2'b00, 16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{2'b01, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{2'b01, 16'hFFFE, 16'hFFFE, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{2'b10, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1'b1};
        tbl[4] = '{2'b11, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{2'b00, 16'h8001, 16'h8001, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; start = 1'b1; continuous = 1'b0; res_ready = 1'b1;
        mode = 2'b00; cnt_value = 16'h0000;

        // Reset held with start asserted, then release with start still high.
        tick(); tick();
        chk_all_zero("reset_outs");
        rst = 1'b0;
        push_res(16'h0000, 1'b0, 1'b0);
        tick();
        start = 1'b0;
        chk1("busy_after_reset_start", busy, 1'b1);
        wait_idle(100);

        // Single inverter measurement with exact cycle windows.
        mode = 2'b00; cnt_value = 16'h1234; res_ready = 1'b1; start = 1'b1;
        push_res(16'h1234, 1'b0, 1'b0);
        for (int c = 1; c <= VLD + 3; c++) begin
            tick();
            start = 1'b0;
            chk1("inv_en_inv", osc_en_inv, (c >= 1 && c <= S + 1 + G));
            chk1("inv_en_nand", osc_en_nand, 1'b0);
            chk1("inv_sel", osc_sel, 1'b0);
            chk1("inv_clr", cnt_clr, (c == S + 1));
            chk1("inv_gate", cnt_gate, (c >= S + 2 && c <= S + 1 + G));
            chk1("inv_valid", res_valid, (c == VLD));
            chk1("inv_busy", busy, (c <= VLD));
        end

        // Alternate round with back-pressure on the first result.
        mode = 2'b10; cnt_value = 16'h0777; res_ready = 1'b0; start = 1'b1;
        push_res(16'h0777, 1'b0, 1'b0);
        push_res(16'h0777, 1'b1, 1'b0);
        for (int c = 1; c <= 52; c++) begin
            tick();
            start = 1'b0;
            res_ready = (c >= 30);
            chk1("alt_valid", res_valid, ((c >= 19 && c <= 30) || c == 49));
            if (c >= 19 && c <= 30) chkw("alt_data_stable", res_data, 16'h0777);
            chk1("alt_en_inv", osc_en_inv, (c >= 1 && c <= 15));
            chk1("alt_en_nand", osc_en_nand, (c >= 31 && c <= 45));
            chk1("alt_sel", osc_sel, (c >= 31));
            chk1("alt_busy", busy, (c <= 49));
        end

        // Continuous NAND rounds; continuous drops during the second round.
        mode = 2'b01; cnt_value = 16'h0042; res_ready = 1'b1; continuous = 1'b1; start = 1'b1;
        push_res(16'h0042, 1'b1, 1'b0);
        push_res(16'h0042, 1'b1, 1'b0);
        for (int c = 1; c <= 42; c++) begin
            tick();
            start = 1'b0;
            if (c == 25) continuous = 1'b0;
            chk1("cont_valid", res_valid, (c == 19 || c == 38));
            chk1("cont_en_nand", osc_en_nand, ((c >= 1 && c <= 15) || (c >= 20 && c <= 34)));
            chk1("cont_en_inv", osc_en_inv, 1'b0);
            chk1("cont_busy", busy, (c <= 38));
        end

        // A start pulse mid-round is ignored.
        mode = 2'b00; cnt_value = 16'h0F0F; start = 1'b1;
        push_res(16'h0F0F, 1'b0, 1'b0);
        for (int c = 1; c <= 45; c++) begin
            tick();
            start = (c == 8);
            chk1("busystart_busy", busy, (c <= VLD));
            chk1("busystart_valid", res_valid, (c == VLD));
        end

        // Reset during the gate window aborts the round.
        mode = 2'b00; cnt_value = 16'h5555; start = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            start = 1'b0;
            if (c == 11) begin
                rst = 1'b0;
                chk_all_zero("midgate_reset_outs");
            end
            if (c == 10) chk1("midgate_gate_on", cnt_gate, 1'b1);
            chk1("midgate_busy", busy, (c <= 10));
            chk1("midgate_valid", res_valid, 1'b0);
            if (c == 10) rst = 1'b1;
        end

        // Table-driven rounds covering data, id and saturation.
        for (int i = 0; i < 6; i++) begin
            push_res(tbl[i].exp_data, tbl[i].exp_id, tbl[i].exp_sat);
            if (tbl[i].alt) push_res(tbl[i].exp_data, 1'b1, tbl[i].exp_sat);
            mode = tbl[i].mode; cnt_value = tbl[i].cnt; res_ready = 1'b1;
            continuous = 1'b0; start = 1'b1;
            tick();
            start = 1'b0;
            chk1("tbl_busy_after_start", busy, 1'b1);
            wait_idle(200);
        end

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover got=%0d want=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
